// File: rtl/rf_writeback_arbiter.sv
// rf_writeback_arbiter: round-robin writeback arbiter feeding one register
// file write port. Collects results from NUM_SRC units over valid/ready,
// grants one per cycle and registers the winning write. Writes to x0 are
// accepted (they consume the turn) but never raise wen.
module rf_writeback_arbiter #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_SRC    = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_SRC-1:0]              src_valid,
    output logic [NUM_SRC-1:0]              src_ready,
    input  logic [NUM_SRC*ADDR_WIDTH-1:0]   src_addr,
    input  logic [NUM_SRC*DATA_WIDTH-1:0]   src_data,
    input  logic                            wb_stall,
    output logic [ADDR_WIDTH-1:0]           waddr,
    output logic [DATA_WIDTH-1:0]           wdata,
    output logic                            wen,
    output logic [15:0]                     wr_count
);

    localparam int PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    // Registered write-port state, kept together so reset/hold stay in step.
    typedef struct packed {
        logic                  wen;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
    } wb_t;

    wb_t                                   wb_q;
    logic [PTR_W-1:0]                      rr_ptr;
    logic [15:0]                           cnt_q;

    // Packed per-source views of the flat input buses.
    logic [NUM_SRC-1:0][ADDR_WIDTH-1:0]    addr_arr;
    logic [NUM_SRC-1:0][DATA_WIDTH-1:0]    data_arr;

    logic                                  grant_vld;
    logic [PTR_W-1:0]                      grant_idx;
    logic [PTR_W-1:0]                      next_ptr;
    logic                                  xfer;
    logic [ADDR_WIDTH-1:0]                 sel_addr;
    logic [DATA_WIDTH-1:0]                 sel_data;

    assign addr_arr = src_addr;
    assign data_arr = src_data;

    // Round-robin scan: first valid source starting at rr_ptr, wrapping.
    always_comb begin
        logic [PTR_W:0] idx;
        grant_vld = 1'b0;
        grant_idx = '0;
        idx       = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            idx = {1'b0, rr_ptr} + (PTR_W+1)'(k);
            if (idx >= (PTR_W+1)'(NUM_SRC))
                idx = idx - (PTR_W+1)'(NUM_SRC);
            if (!grant_vld && src_valid[idx[PTR_W-1:0]]) begin
                grant_vld = 1'b1;
                grant_idx = idx[PTR_W-1:0];
            end
        end
    end

    // Ready is one-hot on the winner; nothing is accepted in reset or stall.
    always_comb begin
        src_ready = '0;
        if (rst && !wb_stall && grant_vld)
            src_ready[grant_idx] = 1'b1;
    end

    assign xfer     = |src_ready;
    assign sel_addr = addr_arr[grant_idx];
    assign sel_data = data_arr[grant_idx];
    assign next_ptr = (grant_idx == PTR_W'(NUM_SRC - 1)) ? '0 : grant_idx + 1'b1;

    // Write-port register, round-robin pointer and saturating commit counter.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wb_q   <= '0;
            rr_ptr <= '0;
            cnt_q  <= '0;
        end else if (xfer) begin
            wb_q.addr <= sel_addr;
            wb_q.data <= sel_data;
            wb_q.wen  <= (sel_addr != '0);
            rr_ptr    <= next_ptr;
            if (sel_addr != '0 && cnt_q != 16'hFFFF)
                cnt_q <= cnt_q + 16'd1;
        end else begin
            wb_q.wen <= 1'b0;
        end
    end

    assign waddr    = wb_q.addr;
    assign wdata    = wb_q.data;
    assign wen      = wb_q.wen;
    assign wr_count = cnt_q;

endmodule
